// File: rtl/led_cpu_pkg.sv
// Shared opcode, state and instruction-field definitions for the LED accumulator CPU.
package led_cpu_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned WORD_W = 16;
    localparam int unsigned OP_W   = 4;

    localparam int unsigned OP_HI  = 15;
    localparam int unsigned OP_LO  = 12;
    localparam int unsigned IMM_HI = 7;
    localparam int unsigned IMM_LO = 0;

    localparam logic [OP_W-1:0] OP_NOP  = 4'h0;
    localparam logic [OP_W-1:0] OP_LDI  = 4'h1;
    localparam logic [OP_W-1:0] OP_ADDI = 4'h2;
    localparam logic [OP_W-1:0] OP_SUBI = 4'h3;
    localparam logic [OP_W-1:0] OP_ANDI = 4'h4;
    localparam logic [OP_W-1:0] OP_ORI  = 4'h5;
    localparam logic [OP_W-1:0] OP_XORI = 4'h6;
    localparam logic [OP_W-1:0] OP_OUT  = 4'h7;
    localparam logic [OP_W-1:0] OP_JMP  = 4'h8;
    localparam logic [OP_W-1:0] OP_JZ   = 4'h9;
    localparam logic [OP_W-1:0] OP_JC   = 4'hA;
    localparam logic [OP_W-1:0] OP_WAIT = 4'hB;
    localparam logic [OP_W-1:0] OP_LDM  = 4'hC;
    localparam logic [OP_W-1:0] OP_HALT = 4'hF;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        EXEC,
        WAIT,
        MEMRD,
        MEMWB,
        HALT
    } state_t;

endpackage

// File: rtl/led_cpu_alu.sv
// Combinational 8-bit ALU; ops that do not touch acc or C pass them through.
module led_cpu_alu
    import led_cpu_pkg::*;
(
    input  logic [OP_W-1:0]   op,
    input  logic [DATA_W-1:0] acc,
    input  logic [DATA_W-1:0] imm,
    input  logic              c,
    output logic [DATA_W-1:0] result,
    output logic              c_next
);

    logic [DATA_W:0] wide;

    always_comb begin
        result = acc;
        c_next = c;
        wide   = '0;
        case (op)
            OP_LDI:  result = imm;
            OP_ADDI: begin
                wide   = {1'b0, acc} + {1'b0, imm};
                result = wide[DATA_W-1:0];
                c_next = wide[DATA_W];
            end
            // Bit 8 of the 9-bit difference is set exactly when acc < imm (borrow).
            OP_SUBI: begin
                wide   = {1'b0, acc} - {1'b0, imm};
                result = wide[DATA_W-1:0];
                c_next = wide[DATA_W];
            end
            OP_ANDI: result = acc & imm;
            OP_ORI:  result = acc | imm;
            OP_XORI: result = acc ^ imm;
            default: ;
        endcase
    end

endmodule

// File: rtl/led_cpu_core.sv
// Accumulator CPU sequencer: fetches 16-bit words from sync-read program RAM and drives LEDs.
module led_cpu_core
    import led_cpu_pkg::*;
#(
    parameter int unsigned TICK  = 1,
    parameter int unsigned CNT_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                run,
    output logic [DATA_W-1:0]   ramAddr,
    input  logic [WORD_W-1:0]   ramData,
    output logic [DATA_W-1:0]   led,
    output logic [DATA_W-1:0]   pc,
    output logic                halted,
    output logic                busy
);

    state_t             state, state_nxt;
    logic [DATA_W-1:0]  pc_q, acc_q, led_q;
    logic               c_q, halted_q;
    logic [WORD_W-1:0]  ir_q;
    logic [CNT_W-1:0]   wait_cnt_q;

    logic [OP_W-1:0]    op;
    logic [DATA_W-1:0]  imm;
    logic [DATA_W-1:0]  alu_result;
    logic               alu_c;
    logic               jump_taken;
    logic               wait_start;
    logic               unused_bits;

    assign op         = ramData[OP_HI:OP_LO];
    assign imm        = ramData[IMM_HI:IMM_LO];
    assign wait_start = (op == OP_WAIT) && (imm != '0);
    assign unused_bits = ^{ir_q[WORD_W-1:DATA_W], ramData[11:8]};

    led_cpu_alu u_alu (
        .op     (op),
        .acc    (acc_q),
        .imm    (imm),
        .c      (c_q),
        .result (alu_result),
        .c_next (alu_c)
    );

    // Branch resolution uses the flags as they stand before this instruction.
    always_comb begin
        jump_taken = 1'b0;
        case (op)
            OP_JMP:  jump_taken = 1'b1;
            OP_JZ:   jump_taken = (acc_q == '0);
            OP_JC:   jump_taken = c_q;
            default: jump_taken = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (run) state_nxt = FETCH;
            FETCH: state_nxt = EXEC;
            EXEC: begin
                if (wait_start)          state_nxt = WAIT;
                else if (op == OP_LDM)   state_nxt = MEMRD;
                else if (op == OP_HALT)  state_nxt = HALT;
                else                     state_nxt = run ? FETCH : IDLE;
            end
            WAIT:  if (wait_cnt_q == '0) state_nxt = run ? FETCH : IDLE;
            MEMRD: state_nxt = MEMWB;
            MEMWB: state_nxt = run ? FETCH : IDLE;
            HALT:  state_nxt = HALT;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= '0;
            acc_q      <= '0;
            c_q        <= 1'b0;
            led_q      <= '0;
            halted_q   <= 1'b0;
            ir_q       <= '0;
            wait_cnt_q <= '0;
        end else begin
            case (state)
                EXEC: begin
                    ir_q  <= ramData;
                    pc_q  <= jump_taken ? imm : pc_q + DATA_W'(1);
                    acc_q <= alu_result;
                    c_q   <= alu_c;
                    if (op == OP_OUT)  led_q    <= acc_q;
                    if (op == OP_HALT) halted_q <= 1'b1;
                    if (wait_start)
                        wait_cnt_q <= CNT_W'(imm) * CNT_W'(TICK) - CNT_W'(1);
                end
                WAIT:  if (wait_cnt_q != '0) wait_cnt_q <= wait_cnt_q - CNT_W'(1);
                MEMWB: acc_q <= ramData[IMM_HI:IMM_LO];
                default: ;
            endcase
        end
    end

    assign ramAddr = (state == MEMRD || state == MEMWB) ? ir_q[IMM_HI:IMM_LO] : pc_q;
    assign led     = led_q;
    assign pc      = pc_q;
    assign halted  = halted_q;
    assign busy    = (state != IDLE) && (state != HALT);

endmodule

// File: tb/tb_led_cpu_core.sv
// Directed bench for led_cpu_core with a behavioural sync-read program RAM.
module tb_led_cpu_core;

    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic [7:0]  ramAddr;
    logic [15:0] ramData;
    logic [7:0]  led;
    logic [7:0]  pc;
    logic        halted;
    logic        busy;

    logic [15:0] mem [256];
    int          n_vec = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    always @(posedge clk) ramData <= mem[ramAddr];

    led_cpu_core #(.TICK(4), .CNT_W(32)) dut (
        .clk     (clk),
        .rst     (rst),
        .run     (run),
        .ramAddr (ramAddr),
        .ramData (ramData),
        .led     (led),
        .pc      (pc),
        .halted  (halted),
        .busy    (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic restart();
        rst = 1'b1;
        run = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        step(2);
        rst = 1'b0;
    endtask

    task automatic wait_halt(input string tag, input int budget);
        int k;
        k = 0;
        while (halted !== 1'b1 && k < budget) begin
            step(1);
            k++;
        end
        chk(tag, 32'(halted), 32'd1);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_led"},    32'(led),     32'h00);
        chk({tag, "_pc"},     32'(pc),      32'h00);
        chk({tag, "_halted"}, 32'(halted),  32'd0);
        chk({tag, "_busy"},   32'(busy),    32'd0);
        chk({tag, "_addr"},   32'(ramAddr), 32'h00);
    endtask

    initial begin
        int bcnt;

        // LDI / OUT / HALT timing
        restart();
        mem[0] = 16'h1005; mem[1] = 16'h7000; mem[2] = 16'hF000;
        step(1);
        chk_reset("rst");
        run = 1'b1;
        step(4);
        chk("out_early_led", 32'(led), 32'h00);
        step(1);
        chk("out_led", 32'(led), 32'h05);
        step(1);
        chk("halt_early", 32'(halted), 32'd0);
        step(1);
        chk("halt_flag", 32'(halted), 32'd1);
        chk("halt_pc", 32'(pc), 32'h03);
        chk("halt_busy", 32'(busy), 32'd0);
        run = 1'b0;
        step(3);
        chk("halt_sticky", 32'(halted), 32'd1);
        chk("halt_pc_hold", 32'(pc), 32'h03);

        // ADDI carry-out feeds JC
        restart();
        mem[0] = 16'h10FF; mem[1] = 16'h2002; mem[2] = 16'hA010;
        mem[16] = 16'h7000; mem[17] = 16'hF000;
        run = 1'b1;
        wait_halt("addc_halt", 40);
        chk("addc_led", 32'(led), 32'h01);
        chk("addc_pc", 32'(pc), 32'h12);

        // SUBI borrow feeds JC
        restart();
        mem[0] = 16'h1000; mem[1] = 16'h3001; mem[2] = 16'hA010;
        mem[16] = 16'h7000; mem[17] = 16'hF000;
        run = 1'b1;
        wait_halt("subb_halt", 40);
        chk("subb_led", 32'(led), 32'hFF);
        chk("subb_pc", 32'(pc), 32'h12);

        // JZ taken
        restart();
        mem[0] = 16'h1000; mem[1] = 16'h9020; mem[32] = 16'hF000;
        run = 1'b1;
        step(5);
        chk("jz_taken_pc", 32'(pc), 32'h20);
        wait_halt("jz_taken_halt", 20);
        chk("jz_taken_endpc", 32'(pc), 32'h21);

        // JZ not taken
        restart();
        mem[0] = 16'h1001; mem[1] = 16'h9020; mem[2] = 16'hF000;
        run = 1'b1;
        step(5);
        chk("jz_nt_pc", 32'(pc), 32'h02);
        wait_halt("jz_nt_halt", 20);
        chk("jz_nt_endpc", 32'(pc), 32'h03);

        // WAIT 3 with TICK=4: FETCH+EXEC+12 WAIT+FETCH+EXEC busy cycles
        restart();
        mem[0] = 16'hB003; mem[1] = 16'hF000;
        run = 1'b1;
        bcnt = 0;
        for (int k = 0; k < 60 && halted !== 1'b1; k++) begin
            step(1);
            if (busy === 1'b1) bcnt++;
        end
        chk("wait_busy_cycles", 32'(bcnt), 32'd16);
        chk("wait_halted", 32'(halted), 32'd1);
        chk("wait_led", 32'(led), 32'h00);

        // LDM from 0x40 takes four cycles before the OUT
        restart();
        mem[0] = 16'hC040; mem[1] = 16'h7000; mem[2] = 16'hF000;
        mem[64] = 16'hAB12;
        run = 1'b1;
        step(3);
        chk("ldm_addr", 32'(ramAddr), 32'h40);
        chk("ldm_busy", 32'(busy), 32'd1);
        step(3);
        chk("ldm_led_early", 32'(led), 32'h00);
        step(1);
        chk("ldm_led", 32'(led), 32'h12);
        wait_halt("ldm_halt", 10);

        // Drop run mid-WAIT: wait finishes, park in IDLE, resume at saved pc
        restart();
        mem[0] = 16'h1009; mem[1] = 16'hB002; mem[2] = 16'h7000; mem[3] = 16'hF000;
        run = 1'b1;
        step(6);
        chk("park_in_wait", 32'(busy), 32'd1);
        run = 1'b0;
        for (int k = 0; k < 40 && busy === 1'b1; k++) step(1);
        chk("park_busy", 32'(busy), 32'd0);
        chk("park_pc", 32'(pc), 32'h02);
        chk("park_led", 32'(led), 32'h00);
        step(5);
        chk("park_pc_hold", 32'(pc), 32'h02);
        chk("park_not_halted", 32'(halted), 32'd0);
        run = 1'b1;
        step(3);
        chk("resume_led", 32'(led), 32'h09);
        wait_halt("resume_halt", 20);
        chk("resume_pc", 32'(pc), 32'h04);

        // Reset in the middle of LDM
        restart();
        mem[0] = 16'h1033; mem[1] = 16'h7000; mem[2] = 16'hC040; mem[3] = 16'h7000;
        mem[4] = 16'hF000; mem[64] = 16'h0077;
        run = 1'b1;
        step(5);
        chk("pre_rst_led", 32'(led), 32'h33);
        step(2);
        chk("pre_rst_addr", 32'(ramAddr), 32'h40);
        rst = 1'b1;
        step(1);
        chk_reset("mid_ldm_rst");
        rst = 1'b0;
        run = 1'b0;
        step(2);
        chk("post_rst_idle", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/led_cpu_core.md
Name: led_cpu_core

Overview:
Accumulator CPU that executes the 16-bit program words loaded into the shared program RAM by the switch-based programming stage, and drives the board LEDs. It sits directly downstream of the RAM write port: it only reads the RAM through the synchronous read port. It is held idle (run=0) while programming is in progress.

Parameters:
TICK, 1, clock cycles per WAIT unit (1 for simulation; board build sets 50_000_000)
CNT_W, 32, width of the WAIT cycle counter; must hold 255*TICK

Ports:
clk      in   1   clock
rst      in   1   reset; synchronous, active-high
run      in   1   level enable; 1 = execute, 0 = park in IDLE after current instruction
ramAddr  out  8   RAM read address (combinational from state)
ramData  in   16  RAM read data, valid one cycle after ramAddr is presented (sync read)
led      out  8   registered LED output
pc       out  8   program counter (debug)
halted   out  1   1 after HALT executed; cleared only by rst
busy     out  1   1 in any state other than IDLE/HALT

Behaviour:
- Instruction word: op=[15:12], unused=[11:8], imm=[7:0]; first programmed byte is the high byte.
- Opcodes: 0 NOP; 1 LDI acc=imm; 2 ADDI acc=acc+imm, C=carry-out; 3 SUBI acc=acc-imm, C=borrow; 4 ANDI; 5 ORI; 6 XORI (4-6 leave C unchanged); 7 OUT led=acc; 8 JMP pc=imm; 9 JZ pc=imm if acc==0; A JC pc=imm if C==1; B WAIT stall imm*TICK cycles; C LDM acc=mem[imm][7:0]; F HALT; D,E execute as NOP.
- Arithmetic is 8-bit, wraps mod 256. pc increments mod 256 (0xFF -> 0x00) unless a taken jump.
- Reset values: state=IDLE, pc=0, acc=0, C=0, led=0, halted=0, ir=0, waitCnt=0.
- ramAddr = pc in IDLE/FETCH/EXEC/WAIT/HALT; = ir[7:0] in MEMRD/MEMWB.
- States:
  IDLE: run=1 -> FETCH, else stay.
  FETCH: RAM samples pc at end of cycle -> EXEC.
  EXEC: ramData is the instruction; ir<=ramData; execute. Next state: WAIT if op=B and imm!=0 (waitCnt<=imm*TICK-1); MEMRD if op=C; HALT if op=F; otherwise FETCH if run=1, else IDLE.
  WAIT: waitCnt decrements; at 0 -> FETCH (or IDLE if run=0).
  MEMRD: RAM samples ir[7:0] -> MEMWB.
  MEMWB: acc<=ramData[7:0] -> FETCH/IDLE per run.
  HALT: halted=1, stays until rst; run ignored.
- Latency: 2 cycles per plain instruction, 4 for LDM, 2+imm*TICK for WAIT. OUT: led updates on the clock edge that ends EXEC.
- run=0 mid-instruction: the instruction completes and pc is advanced; the core parks in IDLE; pc, acc, and C are preserved. run=1 resumes at the saved pc.
- rst has priority over everything, in any state, including mid-WAIT and mid-LDM.
- WAIT imm=0 behaves as NOP.

Decomposition:
- Shared package led_cpu_pkg: 4-bit opcode constants (OP_NOP..OP_HALT), state enum (IDLE, FETCH, EXEC, WAIT, MEMRD, MEMWB, HALT), field index constants.
- One natural sub-module: led_cpu_alu. It is combinational; inputs are op, acc, imm, and C; outputs are result and next C.
- Sequencer, registers, and wait counter stay in led_cpu_core.

Test Plan:
- Program {0:0x1005, 1:0x7000, 2:0xF000}, rst then run=1 -> led=0x05 by cycle 5 after run; halted=1 by cycle 7; pc=0x03.
- Program {0x10FF, 0x2002, 0xA010}, HALT at 0x10 -> acc=0x01, C=1, pc jumps to 0x10, halted=1; repeat with 0x3001 on acc=0x00 -> acc=0xFF, C=1 (borrow).
- Program {0x1000, 0x9020}, HALT at 0x20 -> pc=0x20. Repeat with 0x1001 -> JZ not taken, pc=0x02.
- TICK=4, program {0xB003, 0xF000} -> busy for exactly 12 cycles in WAIT. Then HALT; led unchanged at 0x00.
- mem[0x40]=0xAB12, program {0xC040, 0x7000, 0xF000} -> LDM takes 4 cycles; led=0x12.
- Drop run during WAIT -> WAIT completes, core parks in IDLE with pc=next, busy=0; run=1 resumes at that pc. Assert rst mid-LDM -> all outputs return to reset values the next cycle.
